// File: rtl/dmem_responder_if.sv
// Load/store port between the MEM stage (master) and the data-memory responder (slave).
// Both channels use valid/ready: a beat transfers on a rising edge where valid && ready.
interface dmem_responder_if #(
  parameter int ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressed little-endian data memory answering one load/store at a time
// after WAIT_CYCLES wait states; misaligned or illegal accesses return an error.
module dmem_responder #(
  parameter int          ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_responder_if.slave    bus,
  output logic [1:0]         o_dbg_state
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t            r_state, w_next_state;
  logic              r_ready;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [7:0]        r_mem [0:(1<<ADDR_W)-1];

  logic [7:0]        w_b0, w_b1, w_b2, w_b3;
  logic [31:0]       w_load;
  logic [3:0]        w_be;
  logic              w_err;
  logic              w_accept;
  logic              w_commit;

  assign w_accept = bus.req_valid && r_ready;
  assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);

  // Access decode works on the captured request only.
  always_comb begin
    w_b0   = r_mem[r_addr];
    w_b1   = r_mem[r_addr + ADDR_W'(1)];
    w_b2   = r_mem[r_addr + ADDR_W'(2)];
    w_b3   = r_mem[r_addr + ADDR_W'(3)];
    w_load = 32'd0;
    w_be   = 4'b0000;
    w_err  = 1'b0;
    case (r_funct3)
      3'd0: begin
        w_be   = 4'b0001;
        w_load = {{24{w_b0[7]}}, w_b0};
      end
      3'd4: begin
        w_be   = 4'b0001;
        w_load = {24'd0, w_b0};
        w_err  = r_we;
      end
      3'd1: begin
        w_be   = 4'b0011;
        w_load = {{16{w_b1[7]}}, w_b1, w_b0};
        w_err  = r_addr[0];
      end
      3'd5: begin
        w_be   = 4'b0011;
        w_load = {16'd0, w_b1, w_b0};
        w_err  = r_addr[0] | r_we;
      end
      3'd2: begin
        w_be   = 4'b1111;
        w_load = {w_b3, w_b2, w_b1, w_b0};
        w_err  = |r_addr[1:0];
      end
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_next_state  = r_state;
    bus.rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_WAIT;
      S_WAIT: if (r_cnt == 4'd0) w_next_state = S_RESP;
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign bus.req_ready = r_ready;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign o_dbg_state   = r_state;

  // req_ready is registered so it stays low until the first edge after reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b0;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ready <= (w_next_state == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_cnt    <= 4'(WAIT_CYCLES);
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rdata <= (r_we || w_err) ? 32'd0 : w_load;
            r_err   <= w_err;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory contents survive reset; only a committing error-free store writes.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[r_addr + ADDR_W'(i)] <= r_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the five-stage RISC-V pipeline's MEM stage. It is the target end of the pipeline's load/store port. It holds a 2^ADDR_W-byte little-endian data memory and accepts one request at a time over a valid/ready handshake. After a programmable number of wait states it performs the byte, half or word access and returns read data, or an error, over a second valid/ready handshake.

## Interface
Parameters:
- ADDR_W, 8: byte-address width; memory depth is 2^ADDR_W bytes (256 by default).
- WAIT_CYCLES, 2: wait states between request acceptance and the access; legal range 0–15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-high (asserted = 1, despite the name).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 0 lb/sb, 1 lh/sh, 2 lw/sw, 4 lbu, 5 lhu.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low bytes are used for sb/sh.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  pipeline accepts the response.
- rsp_rdata  out  32  load result, sign- or zero-extended; 0 for stores and errors.
- rsp_err  out  1  misaligned address or illegal funct3; valid with rsp_valid.

## Operation
- States:
  - IDLE: req_ready=1.
  - WAIT: a 4-bit counter counts down the wait states.
  - RESP: rsp_valid=1.
- IDLE→WAIT when req_valid&&req_ready at a clock edge:
  - we/funct3/addr/wdata are captured into holding registers.
  - The counter is loaded with WAIT_CYCLES.
- WAIT:
  - If the counter is not 0, decrement.
  - If the counter is 0, the next edge performs the access and moves to RESP.
- RESP→IDLE at the edge where rsp_ready=1. rsp_valid, rsp_rdata and rsp_err are held stable until then.
- Access rules, using the captured request:
  - lb/lbu: byte mem[a]; lb sign-extends bit 7, lbu zero-extends.
  - lh/lhu: {mem[a+1],mem[a]}; lh sign-extends bit 15, lhu zero-extends.
  - lw: {mem[a+3],mem[a+2],mem[a+1],mem[a]}.
  - sb writes wdata[7:0]; sh writes wdata[15:0]; sw writes all 4 bytes, same little-endian lane order. rsp_rdata=0.
- Error conditions:
  - Half access with a[0]=1.
  - Word access with a[1:0]≠0.
  - Load funct3 ∈{3,6,7}.
  - Store funct3 ∉{0,1,2}.
  - On error: no memory write, rsp_rdata=0, rsp_err=1.
- Aligned accesses never cross the top of memory, so no address wrap-around occurs.
- The memory array is not cleared by reset. It is zero at time 0 in simulation.

## Timing
- Reset values:
  - While rst_n=1: state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
  - req_ready rises the first cycle after rst_n deasserts.
- Latency:
  - Request accepted at edge E.
  - Memory write commits, and rsp_valid/rsp_rdata/rsp_err become visible, after edge E+WAIT_CYCLES+1.
  - With WAIT_CYCLES=0, the response is visible after edge E+1.
- Throughput:
  - With rsp_ready tied high, the response handshake occurs at edge E+WAIT_CYCLES+2.
  - The next request can be accepted at E+WAIT_CYCLES+3.
- No overlap: req_ready is 0 in WAIT and RESP. req_valid there is ignored and does not need to be held stable.
- A load returns memory contents as of the commit edge; earlier completed stores are visible.
- Back-pressure: rsp_ready low holds RESP indefinitely with outputs unchanged.
- Reset mid-operation:
  - Asserting rst_n in WAIT abandons the request with no write.
  - Asserting rst_n in RESP drops the response. The write has already committed and stays.

## Test plan
- WAIT_CYCLES=2, sw addr 0x10 data 0xDEADBEEF accepted at edge 0 -> rsp_valid visible after edge 3, rsp_err=0. Then lw 0x10 -> rsp_rdata=0xDEADBEEF; lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF.
- sb 0x21 data 0x000000AA over zeroed memory, then lw 0x20 -> 0x0000AA00. sh 0x22 data 0x1234, then lw 0x20 -> 0x1234AA00.
- Misaligned and illegal requests: lw 0x11, sh 0x05, load funct3=3, store funct3=4. Each -> rsp_err=1, rsp_rdata=0. A following lw of the targeted word shows it unchanged.
- Back-pressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata, rsp_err stable and req_ready=0 throughout. Pulse req_valid during this window -> not accepted.
- WAIT_CYCLES=0 with rsp_ready=1 and req_valid held high for 4 sw requests -> accepts at edges 0, 3, 6, 9.
- Assert rst_n during WAIT of sw 0x30 data 0x55 -> no write, so a later lw 0x30 returns 0. All outputs read 0 during reset.
